// File: rtl/onehot_decoder_5to32_if.sv
// Select/decode bus for onehot_decoder_5to32: select code in, combinational and
// registered one-hot words plus the registered code out.
interface onehot_decoder_5to32_if;
   logic [4:0]  A;
   logic [31:0] Z;
   logic [31:0] Z_q;
   logic [4:0]  A_q;

   modport master (output A, input Z, input Z_q, input A_q);
   modport slave  (input A, output Z, output Z_q, output A_q);
endinterface

// File: rtl/onehot_decoder_5to32.sv
// 5-to-32 one-hot decoder, Z[(A-1) mod 32] set, with a registered copy of Z and A.
// Optional simulation checker enabled by defining DECODER_ONEHOT_CHECK_EN.
module onehot_decoder_5to32 (
   input  logic                  clk,
   input  logic                  rst_n,
   onehot_decoder_5to32_if.slave bus
);

   logic [4:0]  idx;
   logic [31:0] z_dec;

   // 5-bit wrap makes A=0 select bit 31; an X on A propagates to the whole word.
   always_comb begin
      idx   = bus.A - 5'd1;
      z_dec = 32'd1 << idx;
   end

   assign bus.Z = z_dec;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.Z_q <= '0;
         bus.A_q <= '0;
      end else begin
         bus.Z_q <= z_dec;
         bus.A_q <= bus.A;
      end
   end

`ifdef DECODER_ONEHOT_CHECK_EN
   logic [31:0] z_ref;
   assign z_ref = 32'd1 << ((bus.A - 5'd1) & 5'd31);

   always @(posedge clk) begin
      if (rst_n) begin
         if (!$onehot(bus.Z) || (bus.Z !== z_ref)) begin
            $display("onehot_decoder_5to32 check: A=%0d Z=%h expected=%h", bus.A, bus.Z, z_ref);
            $error("one-hot decode violation");
         end
      end
   end
`else
`endif

endmodule

// File: tb/tb_onehot_decoder_5to32.sv
// Directed table-driven bench for onehot_decoder_5to32: sweep, wrap, registered
// path and asynchronous mid-stream reset.
module tb_onehot_decoder_5to32;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] z;
   } vec_t;

   logic clk;
   logic rst_n;
   onehot_decoder_5to32_if bus ();

   onehot_decoder_5to32 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vec_t        vecs[32];
   int unsigned n_vec;
   int unsigned n_bad;
   logic [4:0]  prev_a;
   logic [31:0] prev_z;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;

      // A = 1..31 select bits 0..30; the last entry is the wrap case A=0 -> bit 31.
      for (int k = 0; k < 31; k++) begin
         vecs[k].a = 5'(k + 1);
         vecs[k].z = 32'h1 << k;
      end
      vecs[31].a = 5'd0;
      vecs[31].z = 32'h8000_0000;

      rst_n = 1'b0;
      bus.A = 5'd1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("reset_Z_q", bus.Z_q, 32'h0);
      check("reset_A_q", {27'd0, bus.A_q}, 32'h0);
      check("reset_Z_live", bus.Z, 32'h0000_0001);
      rst_n = 1'b1;

      prev_a = 5'd1;
      prev_z = 32'h1;
      for (int k = 0; k < 32; k++) begin
         @(posedge clk);
         #1 bus.A = vecs[k].a;
         @(negedge clk);
         check($sformatf("sweep_Z[A=%0d]", vecs[k].a), bus.Z, vecs[k].z);
         check($sformatf("sweep_Z_q[k=%0d]", k), bus.Z_q, prev_z);
         check($sformatf("sweep_A_q[k=%0d]", k), {27'd0, bus.A_q}, {27'd0, prev_a});
         prev_a = vecs[k].a;
         prev_z = vecs[k].z;
      end

      @(posedge clk);
      #1 bus.A = 5'd31;
      @(negedge clk);
      check("wrap_A31", bus.Z, 32'h4000_0000);

      // Registered path, back-to-back codes.
      @(posedge clk);
      #1 bus.A = 5'd3;
      @(posedge clk);
      #1 bus.A = 5'd17;
      check("reg_Z_q_3", bus.Z_q, 32'h0000_0004);
      check("reg_A_q_3", {27'd0, bus.A_q}, 32'd3);
      @(posedge clk);
      #1;
      check("reg_Z_q_17", bus.Z_q, 32'h0001_0000);
      check("reg_A_q_17", {27'd0, bus.A_q}, 32'd17);

      // Asynchronous reset between edges.
      bus.A = 5'd9;
      @(posedge clk);
      #1;
      check("pre_rst_Z_q", bus.Z_q, 32'h0000_0100);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_Z_q", bus.Z_q, 32'h0);
      check("async_rst_A_q", {27'd0, bus.A_q}, 32'h0);
      check("async_rst_Z", bus.Z, 32'h0000_0100);
      bus.A = 5'd2;
      #1;
      check("rst_Z_tracks", bus.Z, 32'h0000_0002);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("release_Z_q_held", bus.Z_q, 32'h0);
      @(posedge clk);
      #1;
      check("first_capture_Z_q", bus.Z_q, 32'h0000_0002);
      check("first_capture_A_q", {27'd0, bus.A_q}, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
